// File: rtl/branch_resolve.sv
// branch_resolve: checks EX branch outcomes against the in-order queue of
// fetch-time predictions. On a mispredict it flushes the pipeline, redirects
// fetch and wipes the wrong-path predictions. It also trains the predictor on
// every resolve and keeps branch/mispredict performance counters.
module branch_resolve #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    input  logic [31:0]      f_pc,
    input  logic             f_pred,
    input  logic [31:0]      f_target,
    output logic             f_ready,
    input  logic             e_valid,
    input  logic [31:0]      e_pc,
    input  logic             e_taken,
    input  logic [31:0]      e_target,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic [31:0]      upd_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic             err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] PERF_ONE = CNT_W'(1);

    // Prediction queue storage, one slot per in-flight predicted branch
    logic [31:0]      pc_q_r  [DEPTH];
    logic [31:0]      tgt_q_r [DEPTH];
    logic [DEPTH-1:0] pred_q_r;

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;
    logic             full_r;

    logic             flush_r;
    logic [31:0]      redirect_pc_r;
    logic             upd_valid_r;
    logic             upd_taken_r;
    logic [31:0]      upd_pc_r;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispred_cnt_r;
    logic             err_r;

    logic             accept_s;
    logic             empty_s;
    logic [31:0]      head_pc_s;
    logic             head_pred_s;
    logic [31:0]      head_tgt_s;
    logic             pc_mis_s;
    logic             mispred_s;
    logic             err_set_s;
    logic             kill_s;
    logic             push_s;
    logic             pop_s;
    logic [PTR_W:0]   count_nxt_s;
    logic [31:0]      redirect_nxt_s;

    // Compare the queue head against the EX outcome and decide on a mispredict
    always_comb begin
        accept_s    = e_valid & ~flush_r;
        empty_s     = (count_r == CNT_ZERO);
        head_pc_s   = pc_q_r[head_r];
        head_pred_s = pred_q_r[head_r];
        head_tgt_s  = tgt_q_r[head_r];
        pc_mis_s    = 1'b0;
        mispred_s   = 1'b0;
        err_set_s   = 1'b0;
        if (empty_s) begin
            // Nothing was predicted: behave as if predicted not-taken, flag the anomaly.
            mispred_s = e_taken;
            err_set_s = 1'b1;
        end else begin
            pc_mis_s  = (head_pc_s != e_pc);
            mispred_s = (head_pred_s != e_taken)
                      | (head_pred_s & e_taken & (head_tgt_s != e_target))
                      | pc_mis_s;
            err_set_s = pc_mis_s;
        end
        kill_s = accept_s & mispred_s;
    end

    // Queue handshake: push/pop qualification and the next occupancy
    always_comb begin
        push_s = f_valid & ~full_r & ~flush_r;
        pop_s  = accept_s & ~empty_s;
        count_nxt_s = count_r;
        if (kill_s) begin
            // Everything behind the mispredicted branch is wrong-path, including a same-cycle push.
            count_nxt_s = CNT_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                2'b11:   count_nxt_s = count_r;
                2'b00:   count_nxt_s = count_r;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Fetch PC after a mispredict: actual target, or fall-through with 32-bit wrap
    always_comb begin
        if (e_taken) begin
            redirect_nxt_s = e_target;
        end else begin
            redirect_nxt_s = e_pc + 32'd4;
        end
    end

    // Queue payload: written at the tail on every accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q_r[i]  <= 32'd0;
                tgt_q_r[i] <= 32'd0;
            end
            pred_q_r <= {DEPTH{1'b0}};
        end else begin
            if (push_s && !kill_s) begin
                pc_q_r[tail_r]   <= f_pc;
                tgt_q_r[tail_r]  <= f_target;
                pred_q_r[tail_r] <= f_pred;
            end
        end
    end

    // Queue pointers, occupancy and the registered full flag behind f_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
            full_r  <= 1'b0;
        end else begin
            if (kill_s) begin
                head_r <= PTR_ZERO;
                tail_r <= PTR_ZERO;
            end else begin
                if (push_s) begin
                    tail_r <= tail_r + PTR_ONE;
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_ONE;
                end
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
        end
    end

    // Resolve results: flush pulse, redirect PC and predictor training strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_r       <= 1'b0;
            redirect_pc_r <= 32'd0;
            upd_valid_r   <= 1'b0;
            upd_taken_r   <= 1'b0;
            upd_pc_r      <= 32'd0;
        end else begin
            flush_r     <= kill_s;
            upd_valid_r <= accept_s;
            if (accept_s) begin
                // Train on every resolve, including mispredicted ones.
                upd_taken_r <= e_taken;
                upd_pc_r    <= e_pc;
            end
            if (kill_s) begin
                redirect_pc_r <= redirect_nxt_s;
            end
        end
    end

    // Performance counters (wrapping) and the sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_r  <= {CNT_W{1'b0}};
            mispred_cnt_r <= {CNT_W{1'b0}};
            err_r         <= 1'b0;
        end else begin
            if (accept_s) begin
                branch_cnt_r <= branch_cnt_r + PERF_ONE;
                if (err_set_s) begin
                    err_r <= 1'b1;
                end
            end
            if (kill_s) begin
                mispred_cnt_r <= mispred_cnt_r + PERF_ONE;
            end
        end
    end

    assign f_ready     = ~full_r;
    assign flush       = flush_r;
    assign redirect_pc = redirect_pc_r;
    assign upd_valid   = upd_valid_r;
    assign upd_taken   = upd_taken_r;
    assign upd_pc      = upd_pc_r;
    assign branch_cnt  = branch_cnt_r;
    assign mispred_cnt = mispred_cnt_r;
    assign err         = err_r;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a scoreboard: resolve stimulus pushes
// the hand-computed result, a negedge monitor pops and compares it.
module tb_branch_resolve;

    logic        clk;
    logic        rst;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        f_pred;
    logic [31:0] f_target;
    logic        f_ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_taken;
    logic [31:0] e_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic        upd_taken;
    logic [31:0] upd_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
    logic        err;

    typedef struct {
        logic        flush;
        logic [31:0] redir;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    branch_resolve #(.DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc), .f_pred(f_pred), .f_target(f_target),
        .f_ready(f_ready),
        .e_valid(e_valid), .e_pc(e_pc), .e_taken(e_taken), .e_target(e_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every training strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (upd_valid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_resolve: upd_valid=1 upd_pc=0x%08h with nothing expected", upd_pc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("flush", {31'd0, flush}, {31'd0, mon_e.flush});
                    if (mon_e.flush) chk("redirect_pc", redirect_pc, mon_e.redir);
                    chk("upd_taken", {31'd0, upd_taken}, {31'd0, mon_e.taken});
                    chk("upd_pc", upd_pc, mon_e.pc);
                    chk("branch_cnt", branch_cnt, mon_e.bcnt);
                    chk("mispred_cnt", mispred_cnt, mon_e.mcnt);
                    chk("err", {31'd0, err}, {31'd0, mon_e.err});
                end
            end else if (flush) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stray_flush: flush=1 without upd_valid, expected 0");
            end
        end
    end

    task automatic exp_push(input logic [31:0] pc, input logic tk, input logic fl,
                            input logic [31:0] redir, input logic [31:0] b,
                            input logic [31:0] m, input logic er);
        exp_t e;
        e.flush = fl; e.redir = redir; e.taken = tk; e.pc = pc;
        e.bcnt = b; e.mcnt = m; e.err = er;
        sb_q.push_back(e);
    endtask

    task automatic do_push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        f_valid = 1'b1; f_pc = pc; f_pred = pred; f_target = tgt;
        @(negedge clk);
        f_valid = 1'b0;
    endtask

    task automatic do_resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                              input logic fl, input logic [31:0] redir,
                              input logic [31:0] b, input logic [31:0] m, input logic er);
        e_valid = 1'b1; e_pc = pc; e_taken = tk; e_target = tgt;
        exp_push(pc, tk, fl, redir, b, m, er);
        @(negedge clk);
        e_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        f_valid = 1'b0; f_pc = 32'd0; f_pred = 1'b0; f_target = 32'd0;
        e_valid = 1'b0; e_pc = 32'd0; e_taken = 1'b0; e_target = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_branch_cnt", branch_cnt, 32'd0);
        chk("rst_mispred_cnt", mispred_cnt, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_f_ready", {31'd0, f_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Correct taken prediction
        do_push(32'h100, 1'b1, 32'h180);
        do_resolve(32'h100, 1'b1, 32'h180, 1'b0, 32'h0, 32'd1, 32'd0, 1'b0);

        // Direction mispredict with a younger entry queued; N+1 push and resolve are dropped
        do_push(32'h200, 1'b0, 32'h0);
        do_push(32'h204, 1'b1, 32'h280);
        do_resolve(32'h200, 1'b1, 32'h240, 1'b1, 32'h240, 32'd2, 32'd1, 1'b0);
        chk("flush_cycle_f_ready", {31'd0, f_ready}, 32'd1);
        f_valid = 1'b1; f_pc = 32'h999; f_pred = 1'b0;
        e_valid = 1'b1; e_pc = 32'h999; e_taken = 1'b1; e_target = 32'h999;
        @(negedge clk);
        f_valid = 1'b0; e_valid = 1'b0;
        chk("flush_one_cycle_a", {31'd0, flush}, 32'd0);
        chk("redirect_hold_a", redirect_pc, 32'h240);

        // Predicted taken, actually not taken -> fall-through
        do_push(32'h300, 1'b1, 32'h310);
        do_resolve(32'h300, 1'b0, 32'h310, 1'b1, 32'h304, 32'd3, 32'd2, 1'b0);
        @(negedge clk);
        chk("flush_one_cycle_b", {31'd0, flush}, 32'd0);
        chk("redirect_hold_b", redirect_pc, 32'h304);

        // Taken with a different target
        do_push(32'h300, 1'b1, 32'h310);
        do_resolve(32'h300, 1'b1, 32'h320, 1'b1, 32'h320, 32'd4, 32'd3, 1'b0);
        @(negedge clk);

        // Fill the queue, overflow attempt, pop while full, pop+push
        do_push(32'h500, 1'b0, 32'h0);
        do_push(32'h504, 1'b0, 32'h0);
        do_push(32'h508, 1'b0, 32'h0);
        do_push(32'h50c, 1'b0, 32'h0);
        chk("full_f_ready", {31'd0, f_ready}, 32'd0);
        f_valid = 1'b1; f_pc = 32'h510; f_pred = 1'b1; f_target = 32'h777;
        e_valid = 1'b1; e_pc = 32'h500; e_taken = 1'b0; e_target = 32'h0;
        exp_push(32'h500, 1'b0, 1'b0, 32'h0, 32'd5, 32'd3, 1'b0);
        #1;
        chk("pop_while_full_f_ready", {31'd0, f_ready}, 32'd0);
        @(negedge clk);
        chk("after_pop_f_ready", {31'd0, f_ready}, 32'd1);
        f_valid = 1'b1; f_pc = 32'h520; f_pred = 1'b0; f_target = 32'h0;
        e_valid = 1'b1; e_pc = 32'h504; e_taken = 1'b0; e_target = 32'h0;
        exp_push(32'h504, 1'b0, 1'b0, 32'h0, 32'd6, 32'd3, 1'b0);
        @(negedge clk);
        f_valid = 1'b0; e_valid = 1'b0;
        chk("push_pop_f_ready", {31'd0, f_ready}, 32'd1);
        do_push(32'h530, 1'b0, 32'h0);
        chk("refull_f_ready", {31'd0, f_ready}, 32'd0);
        do_resolve(32'h508, 1'b0, 32'h0, 1'b0, 32'h0, 32'd7, 32'd3, 1'b0);
        do_resolve(32'h50c, 1'b0, 32'h0, 1'b0, 32'h0, 32'd8, 32'd3, 1'b0);
        do_resolve(32'h520, 1'b0, 32'h0, 1'b0, 32'h0, 32'd9, 32'd3, 1'b0);
        do_resolve(32'h530, 1'b0, 32'h0, 1'b0, 32'h0, 32'd10, 32'd3, 1'b0);
        chk("drained_f_ready", {31'd0, f_ready}, 32'd1);

        // Resolve with an empty queue
        do_resolve(32'h600, 1'b1, 32'h400, 1'b1, 32'h400, 32'd11, 32'd4, 1'b1);
        @(negedge clk);
        chk("err_sticky_a", {31'd0, err}, 32'd1);

        // Fall-through wraps at the top of the address space
        do_push(32'hFFFF_FFFC, 1'b1, 32'h10);
        do_resolve(32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h0, 32'd12, 32'd5, 1'b1);
        @(negedge clk);

        // Reset during a resolve cycle with three entries queued
        do_push(32'h800, 1'b1, 32'h880);
        do_push(32'h804, 1'b1, 32'h884);
        do_push(32'h808, 1'b1, 32'h888);
        rst = 1'b1;
        e_valid = 1'b1; e_pc = 32'h800; e_taken = 1'b0; e_target = 32'h0;
        #1;
        chk("midrst_flush", {31'd0, flush}, 32'd0);
        chk("midrst_branch_cnt", branch_cnt, 32'd0);
        chk("midrst_mispred_cnt", mispred_cnt, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_f_ready", {31'd0, f_ready}, 32'd1);
        @(negedge clk);
        chk("midrst_no_flush_pulse", {31'd0, flush}, 32'd0);
        rst = 1'b0;
        e_valid = 1'b0;
        @(negedge clk);

        // Operation resumes with an empty queue
        do_push(32'h900, 1'b1, 32'h980);
        do_resolve(32'h900, 1'b1, 32'h980, 1'b0, 32'h0, 32'd1, 32'd0, 1'b0);

        // PC mismatch alone raises err and flushes
        do_push(32'hA00, 1'b0, 32'h0);
        do_resolve(32'hA08, 1'b0, 32'h0, 1'b1, 32'hA0C, 32'd2, 32'd1, 1'b1);
        @(negedge clk);
        chk("err_sticky_b", {31'd0, err}, 32'd1);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected results never seen, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
